uart_rx_os: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8-bit, one-sample-per-clock receiver.
- Oversamples rx against an external tick enable.
- Validates start bit, optional parity and stop bit.
- Configurable data width.
- Sits between the pad-side rx line (asynchronous) and the byte-consuming logic. Delivers one-cycle done pulses with error flags.

---
 rtl/uart_rx_os.sv | 150 +++++++++++++++
 tb/tb_uart_rx_os.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with configurable width and parity.
// rx is double-flopped, then sampled mid-bit on tick enables. Each frame ends
// with a one-clock done pulse carrying the word and the parity/frame flags.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision becomes a 2-of-3
// vote over the ticks at mid-1, mid and mid+1. It is off by default, and then
// only the single-sample path is built.
module uart_rx_os #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 tick,
  output logic [DATA_BITS-1:0] dout,
  output logic                 done,
  output logic                 busy,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID     = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LASTBIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rxs;
  logic [TW-1:0]        tcnt;
  logic [3:0]           bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q;
  logic                 armed;
  logic                 bitval;
  logic                 par_x;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] MIDM1     = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] LASTM1    = TW'(OVERSAMPLE - 2);
  localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] DATA_DEC  = '0;
  localparam logic [TW-1:0] RELOAD    = TW'(1);

  logic [1:0] win;

  // Capture the samples at mid-1 and mid; the vote completes with rxs at mid+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= 2'b11;
    end else if (tick) begin
      if ((state == START) ? (tcnt == MIDM1) : (tcnt == LASTM1)) win[0] <= rxs;
      if ((state == START) ? (tcnt == MID) : (tcnt == LAST)) win[1] <= rxs;
    end
  end

  assign bitval = (win[0] & win[1]) | (win[0] & rxs) | (win[1] & rxs);
`else
  localparam logic [TW-1:0] START_DEC = MID;
  localparam logic [TW-1:0] DATA_DEC  = LAST;
  localparam logic [TW-1:0] RELOAD    = '0;

  assign bitval = rxs;
`endif

  assign rxs   = sync[1];
  assign par_x = (^shreg) ^ bitval;

  // Two-flop synchroniser, preset to idle-high so reset never looks like a start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end

  // Frame FSM: everything advances on tick only; done pulses for a single clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      perr_q     <= 1'b0;
      armed      <= 1'b1;
      dout       <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick) begin
        if (rxs) armed <= 1'b1;
        unique case (state)
          IDLE: begin
            if (!rxs && armed) begin
              state <= START;
              tcnt  <= '0;
            end
          end
          START: begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == START_DEC) begin
              if (!bitval) begin
                state  <= DATA;
                tcnt   <= RELOAD;
                bcnt   <= '0;
                busy   <= 1'b1;
                perr_q <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end
          DATA: begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == DATA_DEC) begin
              shreg <= {bitval, shreg[DATA_BITS-1:1]};
              bcnt  <= bcnt + 1'b1;
              if (bcnt == LASTBIT) state <= (PARITY_MODE != 0) ? PARITY : STOP;
            end
          end
          PARITY: begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == DATA_DEC) begin
              perr_q <= (PARITY_MODE == 1) ? ~par_x : par_x;
              state  <= STOP;
            end
          end
          STOP: begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == DATA_DEC) begin
              done       <= 1'b1;
              dout       <= shreg;
              parity_err <= perr_q;
              frame_err  <= ~bitval;
              busy       <= 1'b0;
              armed      <= bitval;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed and randomized frames sent to three receiver builds:
// 8N1, 8 bits with even parity, and 5 bits with odd parity.
// Expected words and flags come from a frame-level model of the UART rules.
module tb_uart_rx_os;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [2:0] rxv;

  logic [7:0] dout0, dout1;
  logic [4:0] dout2;
  logic       done0, done1, done2;
  logic       busy0, busy1, busy2;
  logic       perr0, perr1, perr2;
  logic       ferr0, ferr1, ferr2;

  int checks   = 0;
  int failures = 0;
  int tickDiv  = 1;
  int tickPh   = 0;
  int doneCnt [3] = '{0, 0, 0};
  int busyCyc [3] = '{0, 0, 0};
  int expDone [3] = '{0, 0, 0};
  int cfgBits [3] = '{8, 8, 5};
  int cfgMode [3] = '{0, 2, 1};

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0)) u0 (
    .clk(clk), .rst(rst), .rx(rxv[0]), .tick(tick), .dout(dout0), .done(done0),
    .busy(busy0), .parity_err(perr0), .frame_err(ferr0)
  );

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2)) u1 (
    .clk(clk), .rst(rst), .rx(rxv[1]), .tick(tick), .dout(dout1), .done(done1),
    .busy(busy1), .parity_err(perr1), .frame_err(ferr1)
  );

  uart_rx_os #(.DATA_BITS(5), .OVERSAMPLE(16), .PARITY_MODE(1)) u2 (
    .clk(clk), .rst(rst), .rx(rxv[2]), .tick(tick), .dout(dout2), .done(done2),
    .busy(busy2), .parity_err(perr2), .frame_err(ferr2)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Tick enable: one clk in every tickDiv, changed on the falling edge
  initial begin
    tick = 1'b1;
    forever begin
      @(negedge clk);
      tickPh = (tickPh + 1 >= tickDiv) ? 0 : tickPh + 1;
      tick = (tickPh == 0);
    end
  end

  // Count done pulses and busy cycles per receiver, sampled mid-cycle
  always @(negedge clk) begin
    if (done0) doneCnt[0]++;
    if (done1) doneCnt[1]++;
    if (done2) doneCnt[2]++;
    if (busy0) busyCyc[0]++;
    if (busy1) busyCyc[1]++;
    if (busy2) busyCyc[2]++;
  end

  function automatic logic [8:0] doutOf(input int idx);
    case (idx)
      0:       return 9'(dout0);
      1:       return 9'(dout1);
      default: return 9'(dout2);
    endcase
  endfunction

  function automatic logic busyOf(input int idx);
    case (idx)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic perrOf(input int idx);
    case (idx)
      0:       return perr0;
      1:       return perr1;
      default: return perr2;
    endcase
  endfunction

  function automatic logic ferrOf(input int idx);
    case (idx)
      0:       return ferr0;
      1:       return ferr1;
      default: return ferr2;
    endcase
  endfunction

  // Frame-level model: the word is the low nbits, parity is judged on the count of ones
  function automatic frame_t modelFrame(input int idx, input logic [8:0] data,
                                        input logic pbit, input logic stopb);
    frame_t f;
    int ones;
    f.data = data & 9'((1 << cfgBits[idx]) - 1);
    ones = $countones(f.data) + int'(pbit);
    if (cfgMode[idx] == 0)      f.perr = 1'b0;
    else if (cfgMode[idx] == 1) f.perr = (ones % 2) != 1;
    else                        f.perr = (ones % 2) != 0;
    f.ferr = !stopb;
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
  endtask

  task automatic sendBit(input int idx, input logic b);
    rxv[idx] = b;
    waitTicks(16);
  endtask

  // Drive one whole frame; rx is left at the stop-bit level
  task automatic applyStimulus(input int idx, input logic [8:0] data, input logic pbit,
                               input logic stopb);
    sendBit(idx, 1'b0);
    for (int i = 0; i < cfgBits[idx]; i++) begin
      sendBit(idx, data[i]);
      if (i == 1) begin
        #1;
        checkOutput($sformatf("busy_mid%0d", idx), 16'(busyOf(idx)), 16'd1);
      end
    end
    if (cfgMode[idx] != 0) sendBit(idx, pbit);
    sendBit(idx, stopb);
  endtask

  task automatic expectFrame(input int idx, input logic [8:0] data, input logic pbit,
                             input logic stopb);
    frame_t f;
    f = modelFrame(idx, data, pbit, stopb);
    expDone[idx]++;
    #1;
    checkOutput($sformatf("done_cnt%0d", idx), 16'(doneCnt[idx]), 16'(expDone[idx]));
    checkOutput($sformatf("dout%0d", idx), 16'(doutOf(idx)), 16'(f.data));
    checkOutput($sformatf("parity_err%0d", idx), 16'(perrOf(idx)), 16'(f.perr));
    checkOutput($sformatf("frame_err%0d", idx), 16'(ferrOf(idx)), 16'(f.ferr));
    checkOutput($sformatf("busy_end%0d", idx), 16'(busyOf(idx)), 16'd0);
  endtask

  // Bound the whole run in case the stimulus ever stalls
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8:0] d;
    logic [8:0] doutHold;
    int idx, busyHold, doneHold;
    logic pbit, stopb;

    rst = 1'b1;
    rxv = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dout0", 16'(dout0), 16'd0);
    checkOutput("rst_done0", 16'(done0), 16'd0);
    checkOutput("rst_busy0", 16'(busy0), 16'd0);
    checkOutput("rst_perr1", 16'(perr1), 16'd0);
    checkOutput("rst_ferr2", 16'(ferr2), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    waitTicks(20);

    $display("[TB] 8N1 frame 0xA5");
    applyStimulus(0, 9'h0A5, 1'b0, 1'b1);
    expectFrame(0, 9'h0A5, 1'b0, 1'b1);

    $display("[TB] even parity 0x3C good then bad");
    applyStimulus(1, 9'h03C, 1'b0, 1'b1);
    expectFrame(1, 9'h03C, 1'b0, 1'b1);
    applyStimulus(1, 9'h03C, 1'b1, 1'b1);
    expectFrame(1, 9'h03C, 1'b1, 1'b1);

    $display("[TB] break: 0x55 with low stop, line held low");
    applyStimulus(0, 9'h055, 1'b0, 1'b0);
    expectFrame(0, 9'h055, 1'b0, 1'b0);
    waitTicks(48);
    #1;
    checkOutput("no_retrigger_low", 16'(doneCnt[0]), 16'(expDone[0]));
    checkOutput("idle_in_break", 16'(busy0), 16'd0);
    rxv[0] = 1'b1;
    waitTicks(32);
    applyStimulus(0, 9'h00F, 1'b0, 1'b1);
    expectFrame(0, 9'h00F, 1'b0, 1'b1);

    $display("[TB] short low glitch");
    doutHold = doutOf(0);
    busyHold = busyCyc[0];
    doneHold = doneCnt[0];
    rxv[0] = 1'b0;
    repeat (4) @(posedge clk);
    rxv[0] = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("glitch_busy", 16'(busyCyc[0] - busyHold), 16'd0);
    checkOutput("glitch_done", 16'(doneCnt[0] - doneHold), 16'd0);
    checkOutput("glitch_dout", 16'(dout0), 16'(doutHold));

    $display("[TB] reset during data bit 3");
    d = 9'h0C6;
    sendBit(0, 1'b0);
    sendBit(0, d[0]);
    sendBit(0, d[1]);
    sendBit(0, d[2]);
    rxv[0] = d[3];
    waitTicks(8);
    #1;
    checkOutput("busy_pre_rst", 16'(busy0), 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("arst_dout0", 16'(dout0), 16'd0);
    checkOutput("arst_busy0", 16'(busy0), 16'd0);
    checkOutput("arst_done0", 16'(done0), 16'd0);
    checkOutput("arst_ferr0", 16'(ferr0), 16'd0);
    checkOutput("arst_perr1", 16'(perr1), 16'd0);
    checkOutput("arst_dout1", 16'(dout1), 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rxv[0] = 1'b1;
    waitTicks(32);
    #1;
    checkOutput("no_done_on_abort", 16'(doneCnt[0]), 16'(expDone[0]));
    applyStimulus(0, 9'h081, 1'b0, 1'b1);
    expectFrame(0, 9'h081, 1'b0, 1'b1);

    $display("[TB] 5O1 back-to-back with tick 1 in 4");
    tickDiv = 4;
    applyStimulus(2, 9'h01F, 1'b0, 1'b1);
    expectFrame(2, 9'h01F, 1'b0, 1'b1);
    applyStimulus(2, 9'h000, 1'b1, 1'b1);
    expectFrame(2, 9'h000, 1'b1, 1'b1);

    $display("[TB] randomized frames");
    for (int n = 0; n < 8; n++) begin
      tickDiv = $urandom_range(1, 3);
      idx = $urandom_range(0, 2);
      d = 9'($urandom);
      pbit = 1'($urandom);
      stopb = ($urandom_range(0, 3) != 0);
      applyStimulus(idx, d, pbit, stopb);
      expectFrame(idx, d, pbit, stopb);
      rxv[idx] = 1'b1;
      waitTicks(32);
    end
    #1;
    checkOutput("final_done0", 16'(doneCnt[0]), 16'(expDone[0]));
    checkOutput("final_done1", 16'(doneCnt[1]), 16'(expDone[1]));
    checkOutput("final_done2", 16'(doneCnt[2]), 16'(expDone[2]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
